pulse_stretch: RTL
==================

Name: pulse_stretch

Overview:
- Converts single-cycle event pulses into a level held high for a programmable number of clock cycles.
- This is the pulse-to-level counterpart of the team's edge-detect pulse generator.
- Sits downstream of event/pulse sources, for example to drive LEDs, enables or slow-domain request lines from one-clock strobes.
- Supports retriggering, an enforced low gap between stretches, and counting of dropped pulses.

Parameters:
- LEN_W, 8: width of the runtime stretch-length input.
- RETRIGGER, 0: 1 means a pulse during HOLD reloads the counter and extends the output; 0 means the pulse is dropped and counted as missed.
- GAP_CYCLES, 2: number of forced-low cycles after each stretch, during which pulses are dropped. 0 disables the GAP state.
- MISS_W, 8: width of the saturating missed-pulse counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pulse_in  in  1  event strobe, sampled every edge. Any high cycle is one trigger, so a multi-cycle high counts as multiple triggers.
- len  in  LEN_W  stretch length L in cycles, sampled only on an accepted trigger. len=0 is treated as L=1.
- clr_miss  in  1  synchronous clear of miss_count.
- level_out  out  1  stretched level; registered.
- busy  out  1  high while in HOLD or GAP; registered.
- done  out  1  one-cycle pulse marking the end of a stretch; registered.
- missed  out  1  one-cycle pulse when a trigger is dropped; registered.
- miss_count  out  MISS_W  saturating count of dropped triggers.

Behaviour:
- Reset: a synchronous rst forces state IDLE, counters to 0, and level_out, busy, done, missed and miss_count all to 0.
- Reset dominates every other input.
- Reset applied mid-stretch forces level_out low at that edge with no done pulse.
- FSM states: IDLE, HOLD, GAP.
- Counters: cnt (LEN_W bits) counts remaining HOLD cycles; gcnt counts remaining GAP cycles.
- IDLE:
  - pulse_in=1 -> go to HOLD, load cnt = max(len,1)-1, set level_out=1 and busy=1 at that edge.
  - Latency: a pulse in cycle n gives level_out high in cycles n+1 through n+L exactly.
- HOLD, normal countdown:
  - cnt>0 -> decrement.
  - cnt==0 with no trigger -> level_out=0 and done=1 at that edge.
  - From there, go to GAP (gcnt=GAP_CYCLES-1, busy stays 1) if GAP_CYCLES>0; otherwise go to IDLE with busy=0.
- HOLD with pulse_in=1:
  - RETRIGGER=1: reload cnt = max(len,1)-1 using the current len. level_out stays high continuously and ends L cycles after the retrigger cycle. No done pulse is generated for the interrupted stretch.
  - This includes a trigger on the final cycle (cnt==0): retrigger wins over termination.
  - RETRIGGER=0: the trigger is dropped, missed=1 for one cycle, miss_count increments, and the countdown is unaffected. This also applies on the final HOLD cycle; the trigger is not queued.
- GAP:
  - level_out=0.
  - Any pulse_in is dropped and counted as missed.
  - gcnt==0 -> go to IDLE with busy=0.
  - A pulse in the cycle after GAP exits is accepted normally.
- done and missed cannot occur in the same cycle for a single trigger. They can coincide only when RETRIGGER=0 and a pulse lands on the final HOLD cycle: done=1 and missed=1 together.
- miss_count:
  - Saturates at 2^MISS_W-1 and does not wrap.
  - clr_miss=1 sets it to 0.
  - clr_miss together with a simultaneous missed event sets it to 1, so the event is not lost.
- len changes outside an accepted or retrigger cycle have no effect.
- level_out is glitch-free because it is a direct flop output.

Test Plan:
- Reset, then a single pulse with len=4, GAP_CYCLES=2 -> level_out high in cycles n+1..n+4; done=1 in cycle n+5; busy high for n+1..n+6; busy=0 at n+7.
- len=0 pulse -> level_out high for exactly 1 cycle, then done.
- RETRIGGER=0, len=5, second pulse at n+3 and third pulse inside GAP -> stretch ends at n+5 unchanged; missed pulses in both cycles; miss_count=2.
- RETRIGGER=1, len=3, pulses at n and n+2 (plus a case with the retrigger on the last HOLD cycle) -> level_out continuous from n+1 to n+5; exactly one done, at n+6; missed never asserted.
- Saturation and clear, MISS_W=2: drop 5 pulses -> miss_count 1,2,3,3,3. clr_miss alone -> 0. clr_miss with a simultaneous drop -> 1.
- rst asserted at cycle 2 of a len=10 stretch -> level_out, busy and done all 0 after that edge and no done pulse; a pulse after reset release is accepted normally.

Source files
------------

// File: rtl/pulse_stretch.sv
// pulse_stretch
// Turns one-clock event strobes into a level that stays high for a
// programmable number of cycles. Pulses that arrive during a stretch can
// either extend it or be dropped, and dropped pulses are counted. After each
// stretch an optional forced-low gap keeps the output low.
//
// Parameters:
//   LEN_W      - width of the runtime stretch length
//   RETRIGGER  - 1: a pulse during HOLD reloads the count; 0: it is dropped
//   GAP_CYCLES - forced-low cycles after each stretch (0 = no GAP state)
//   MISS_W     - width of the saturating dropped-pulse counter
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   pulse_in   in   event strobe; every high cycle is one trigger
//   len        in   stretch length L (0 treated as 1), sampled on accept/retrigger
//   clr_miss   in   synchronous clear of miss_count
//   level_out  out  stretched level (flop output)
//   busy       out  high in HOLD or GAP
//   done       out  one-cycle pulse at the end of a stretch
//   missed     out  one-cycle pulse for each dropped trigger
//   miss_count out  saturating count of dropped triggers
//   state_dbg  out  current FSM state (0 IDLE, 1 HOLD, 2 GAP)

module pulse_stretch #(
  parameter int LEN_W      = 8,
  parameter int RETRIGGER  = 0,
  parameter int GAP_CYCLES = 2,
  parameter int MISS_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic [LEN_W-1:0]  len,
  input  logic              clr_miss,
  output logic              level_out,
  output logic              busy,
  output logic              done,
  output logic              missed,
  output logic [MISS_W-1:0] miss_count,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Gap counter holds GAP_CYCLES-1 down to 0; keep it at least one bit wide.
  localparam int GCNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
  logic                level_q, level_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                missed_q, missed_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  logic [LEN_W-1:0]    len_load;
  logic                finish;
  logic                drop;

  // cnt counts remaining HOLD cycles after the current one, so L cycles
  // of level need a load of L-1; len=0 behaves like len=1.
  assign len_load = (len == '0) ? '0 : len - LEN_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      missed_q <= missed_d;
      miss_q   <= miss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    finish  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pulse_in) begin
          state_d = S_HOLD;
          cnt_d   = len_load;
        end
      end
      S_HOLD: begin
        if (pulse_in && (RETRIGGER != 0)) begin
          // Retrigger wins even on the final cycle; no done for this stretch.
          cnt_d = len_load;
        end else begin
          // Without retrigger a pulse is dropped but the countdown proceeds,
          // so done and missed may coincide on the final cycle.
          drop = pulse_in;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - LEN_W'(1);
          end else begin
            finish = 1'b1;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gcnt_d  = GAP_LOAD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_GAP: begin
        drop = pulse_in;
        if (gcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - GCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    level_d  = (state_d == S_HOLD);
    busy_d   = (state_d != S_IDLE);
    done_d   = finish;
    missed_d = drop;
    miss_d   = miss_q;
    if (clr_miss) begin
      // A drop in the clearing cycle is kept rather than lost.
      miss_d = drop ? MISS_W'(1) : '0;
    end else if (drop && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + MISS_W'(1);
    end
  end

  assign level_out  = level_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign missed     = missed_q;
  assign miss_count = miss_q;
  assign state_dbg  = state_q;

endmodule
